// File: rtl/dm_pkg.sv
// Shared types and helpers for the data memory controller.
// Size encodings, FSM states and the byte-enable lane helper.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } dm_state_e;

  // Byte enable for a given access size and byte lane.
  function automatic logic [3:0] lane_be(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request, response and write-log bundle for the data memory.
// The MEM stage is master; the memory controller is slave.
interface data_memory_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_wdata;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  log_valid, log_addr, log_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output log_valid, log_addr, log_wdata
  );

endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: error check, store merge, load extend.
// The merged word combines the old memory word with the new lanes.
module dm_lane_align
  import dm_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        err_o,
  output logic [3:0]  be_o,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  lane;
  logic        hi_bits;
  logic        misal;
  logic [31:0] wrep;
  logic [31:0] mask;
  logic [31:0] shifted;

  assign lane    = addr_i[1:0];
  assign hi_bits = |(addr_i >> ADDR_W);
  assign be_o    = lane_be(size_i, lane);

  // Alignment and legality of the request.
  always_comb begin
    misal = 1'b0;
    unique case (size_i)
      SZ_BYTE: misal = 1'b0;
      SZ_HALF: misal = lane[0];
      SZ_WORD: misal = |lane;
      default: misal = 1'b1;
    endcase
  end

  assign err_o = misal | hi_bits;

  // Replicate store data so every lane carries it.
  always_comb begin
    wrep = wdata_i;
    unique case (size_i)
      SZ_BYTE: wrep = {4{wdata_i[7:0]}};
      SZ_HALF: wrep = {2{wdata_i[15:0]}};
      default: wrep = wdata_i;
    endcase
  end

  assign mask = {{8{be_o[3]}}, {8{be_o[2]}},
                 {8{be_o[1]}}, {8{be_o[0]}}};

  assign merged_o = (rword_i & ~mask) | (wrep & mask);

  assign shifted = rword_i >> {lane, 3'b000};

  // Bring the selected bytes down to bit 0 and extend.
  always_comb begin
    rdata_o = 32'd0;
    unique case (size_i)
      SZ_BYTE:
        rdata_o = {{24{signed_i & shifted[7]}},
                   shifted[7:0]};
      SZ_HALF:
        rdata_o = {{16{signed_i & shifted[15]}},
                   shifted[15:0]};
      SZ_WORD: rdata_o = rword_i;
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte enables and clear engine.
// Responses and the store log are registered one cycle after accept.
module data_memory_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  data_memory_ctrl_if.slave bus
);

  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  dm_state_e   state_q;
  logic [IW-1:0] clr_ptr_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        log_valid_q;
  logic [31:0] log_addr_q;
  logic [31:0] log_wdata_q;

  logic [31:0] mem_q [DEPTH];

  logic [IW-1:0] req_idx;
  logic [31:0]   rword;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   merged;
  logic [31:0]   rdata;
  logic          accept;
  logic          st_ok;
  logic          clearing;
  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [31:0]   mem_d;

  assign req_idx  = bus.req_addr[ADDR_W-1:2];
  assign rword    = mem_q[req_idx];
  assign accept   = bus.req_valid & ready_q;
  assign st_ok    = accept & bus.req_we & ~err;
  assign clearing = (state_q == ST_CLEAR) & ~reset;

  dm_lane_align #(.ADDR_W(ADDR_W)) u_align (
    .size_i   (bus.req_size),
    .signed_i (bus.req_signed),
    .addr_i   (bus.req_addr),
    .wdata_i  (bus.req_wdata),
    .rword_i  (rword),
    .err_o    (err),
    .be_o     (be),
    .merged_o (merged),
    .rdata_o  (rdata)
  );

  assign mem_we  = clearing | st_ok;
  assign mem_idx = clearing ? clr_ptr_q : req_idx;
  assign mem_d   = clearing ? 32'd0 : merged;

  // Storage array: no reset, zeroed only by the clear engine.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_d;
  end

  // Control FSM with registered response and log outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_ptr_q   <= '0;
      ready_q     <= ~CLEAR_ON_RESET;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      log_valid_q <= 1'b0;
      log_addr_q  <= 32'd0;
      log_wdata_q <= 32'd0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
        end
      endcase
      rsp_valid_q <= accept;
      rsp_err_q   <= accept & err;
      rsp_rdata_q <= (accept & ~bus.req_we & ~err)
                     ? rdata : 32'd0;
      log_valid_q <= st_ok;
      if (st_ok) begin
        log_addr_q  <= {bus.req_addr[31:2], 2'b00};
        log_wdata_q <= merged;
      end
    end
  end

  logic unused_be;
  assign unused_be = ^be;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.log_valid = log_valid_q;
  assign bus.log_addr  = log_addr_q;
  assign bus.log_wdata = log_wdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl with a byte-array model.
// Directed cases from the plan plus randomized traffic.
module tb_data_memory_ctrl;

  logic clk;
  logic reset;

  data_memory_ctrl_if bus ();

  data_memory_ctrl #(.ADDR_W(13), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        logv;
    logic [31:0] laddr;
    logic [31:0] lwdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ref_mem [8192];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic we,
                                 input logic [1:0] size,
                                 input logic sgn,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t e;
    int nb;
    int a;
    int wa;
    logic [31:0] v;
    e.rdata = 0; e.err = 0; e.logv = 0;
    e.laddr = 0; e.lwdata = 0;
    e.err = (size == 2'd3) ||
            (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'b00) ||
            (addr[31:13] != 0);
    if (e.err) return e;
    nb = 1 << size;
    a  = int'(addr[12:0]);
    if (we) begin
      for (int i = 0; i < nb; i++)
        ref_mem[a+i] = wdata[8*i +: 8];
      wa = a & ~3;
      e.logv   = 1;
      e.laddr  = 32'(wa);
      e.lwdata = {ref_mem[wa+3], ref_mem[wa+2],
                  ref_mem[wa+1], ref_mem[wa]};
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++)
        v = v | (32'(ref_mem[a+i]) << (8*i));
      if (sgn && nb < 4 && v[8*nb-1])
        v = v | ~((32'd1 << (8*nb)) - 1);
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic issue(input logic we,
                       input logic [1:0] size,
                       input logic sgn,
                       input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    sb_q.push_back(model(we, size, sgn, addr, wdata));
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h0;
    while (!bus.req_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
  endtask

  // Monitor: pop an expectation per response.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("log_valid", 32'(bus.log_valid),
                32'(e.logv));
          if (e.logv) begin
            check("log_addr", bus.log_addr, e.laddr);
            check("log_wdata", bus.log_wdata, e.lwdata);
          end
        end
      end else if (bus.log_valid) begin
        check("stray_log", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [1:0]  sz;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_log_valid", 32'(bus.log_valid), 32'd0);
    check("rst_log_addr", bus.log_addr, 32'd0);
    check("rst_log_wdata", bus.log_wdata, 32'd0);
    reset = 1'b0;
    wait_ready(n);
    check("clear_cycles", 32'(n), 32'd2048);
    clear_model();

    issue(0, 2'd2, 0, 32'h1FFC, 0);
    issue(1, 2'd2, 0, 32'h10, 32'h8765_4321);
    issue(0, 2'd0, 1, 32'h13, 0);
    issue(0, 2'd0, 0, 32'h13, 0);
    issue(0, 2'd1, 1, 32'h12, 0);
    issue(0, 2'd1, 0, 32'h10, 0);
    issue(1, 2'd2, 0, 32'h20, 0);
    issue(1, 2'd0, 0, 32'h21, 32'hAB);
    issue(1, 2'd1, 0, 32'h22, 32'hBEEF);
    issue(1, 2'd2, 0, 32'h30, 32'hCAFE_F00D);
    issue(1, 2'd1, 0, 32'h31, 32'h1111);
    issue(0, 2'd2, 0, 32'h22, 0);
    issue(1, 2'd2, 0, 32'h2000, 32'h2222_2222);
    issue(1, 2'd3, 0, 32'h30, 32'h3333_3333);
    issue(0, 2'd2, 0, 32'h30, 0);
    issue(1, 2'd2, 0, 32'h40, 32'h1234_5678);
    issue(0, 2'd2, 0, 32'h40, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 400; k++) begin
      a  = 32'($urandom_range(0, 127));
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) sz = 2'd3;
      if ($urandom_range(0, 15) == 0) a = a | 32'h2000;
      if ($urandom_range(0, 31) == 0) a = a | 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) a = a | 32'h1F80;
      if ($urandom_range(0, 7) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      issue(1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), a, $urandom);
    end
    idle();

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("mid_clear_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(n);
    check("reclear_cycles", 32'(n), 32'd2048);
    clear_model();
    issue(0, 2'd2, 0, 32'h40, 0);
    issue(0, 2'd2, 0, 32'h1FFC, 0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
